// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, single-request imem handshake and a
// registered instruction slot for the decoder. Optional perf counters: IFETCH_PERF_CNT_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
);

    // Handshake: a fetch completes in any cycle where imem_req=1 and
    // imem_ready=1; imem_addr stays stable while the request is outstanding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        capture;
    logic        miss;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                // A held (stalled) instruction blocks new requests.
                imem_req = !(inst_valid && stall);
                if (imem_req) begin
                    if (imem_ready) begin
                        capture = 1'b1;
                    end else begin
                        miss       = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Redirect wins over everything except reset; returned data is dropped.
        if (redirect) begin
            capture    = 1'b0;
            miss       = 1'b0;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC_ALIGNED;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            inst_valid <= 1'b0;
        end else if (capture) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + 32'd4;
        end else if (miss) begin
            // The held instruction is consumed in the same cycle as the miss.
            inst_valid <= 1'b0;
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = inst_pc + 32'd4;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (state == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign wait_count  = wait_cnt_q;
`else
    assign fetch_count = 32'd0;
    assign wait_count  = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: zero-wait streaming, wait states, stall,
// redirect during WAIT, PC wrap and reset in the middle of a wait.
module tb_ifetch_unit;

    localparam logic [31:0] RDATA_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;
    logic [31:0] wait_count;

    int errors = 0;
    int checks = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_pc    (inst_pc),
        .pc_plus4   (pc_plus4),
        .fetch_count(fetch_count),
        .wait_count (wait_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word's contents are derived from its address.
    assign imem_rdata = imem_addr ^ RDATA_KEY;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Inputs change just after the negedge; outputs are checked before the next posedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] pc_exp);
        check({tag, " valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, " inst_pc"}, inst_pc, pc_exp);
        check({tag, " inst"}, inst, pc_exp ^ RDATA_KEY);
        check({tag, " pc_plus4"}, pc_plus4, pc_exp + 32'd4);
    endtask

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        @(negedge clk);
        step();

        // reset state
        check("rst req", {31'd0, imem_req}, 32'd0);
        check("rst valid", {31'd0, inst_valid}, 32'd0);
        check("rst inst", inst, 32'd0);
        check("rst inst_pc", inst_pc, 32'd0);
        check("rst fetch_count", fetch_count, 32'd0);
        check("rst wait_count", wait_count, 32'd0);

        reset = 1'b0;
        #1;
        check("idle req", {31'd0, imem_req}, 32'd0);
        step();
        check("run0 req", {31'd0, imem_req}, 32'd1);
        check("run0 addr", imem_addr, 32'h0);
        check("run0 valid", {31'd0, inst_valid}, 32'd0);

        // zero-wait streaming
        step();
        expect_inst("s0", 32'h0);
        check("s0 addr", imem_addr, 32'h4);
        step();
        expect_inst("s1", 32'h4);
        check("s1 addr", imem_addr, 32'h8);
        step();
        expect_inst("s2", 32'h8);
        step();
        expect_inst("s3", 32'hC);
        check("s3 addr", imem_addr, 32'h10);

        // three wait cycles at 0x10
        imem_ready = 1'b0;
        #1;
        check("miss req", {31'd0, imem_req}, 32'd1);
        step();
        check("w1 valid", {31'd0, inst_valid}, 32'd0);
        check("w1 addr", imem_addr, 32'h10);
        stall = 1'b1;
        #1;
        check("w1 stall req", {31'd0, imem_req}, 32'd1);
        step();
        stall = 1'b0;
        step();
        check("w3 valid", {31'd0, inst_valid}, 32'd0);
        check("w3 addr", imem_addr, 32'h10);
        check("w3 req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        step();
        expect_inst("wcap", 32'h10);
        check("wcap addr", imem_addr, 32'h14);
`ifdef IFETCH_PERF_CNT_EN
        check("wait_count", wait_count, 32'd3);
        check("fetch_count", fetch_count, 32'd5);
`else
        check("wait_count off", wait_count, 32'd0);
        check("fetch_count off", fetch_count, 32'd0);
`endif

        // advance to inst_pc 0x20, then stall two cycles
        for (int i = 0; i < 4; i++) step();
        expect_inst("pre-stall", 32'h20);
        stall = 1'b1;
        #1;
        check("stall req", {31'd0, imem_req}, 32'd0);
        step();
        expect_inst("stall1", 32'h20);
        step();
        expect_inst("stall2", 32'h20);
        check("stall2 addr", imem_addr, 32'h24);
        stall = 1'b0;
        #1;
        check("release req", {31'd0, imem_req}, 32'd1);
        step();
        expect_inst("post-stall", 32'h24);

        // redirect while waiting, with data arriving the same cycle
        imem_ready = 1'b0;
        step();
        check("rw addr", imem_addr, 32'h28);
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        #1;
        check("redir valid", {31'd0, inst_valid}, 32'd0);
        check("redir addr", imem_addr, 32'h100);
        check("redir req", {31'd0, imem_req}, 32'd1);
        step();
        expect_inst("redir cap", 32'h100);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        #1;
        check("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step();
        expect_inst("wrap cap", 32'hFFFF_FFFC);
        check("wrap pc_plus4", pc_plus4, 32'h0);
        check("wrap next addr", imem_addr, 32'h0);

        // reset in the middle of a wait, redirect asserted alongside
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        step();
        check("pre-rst addr", imem_addr, 32'h200);
        check("pre-rst valid", {31'd0, inst_valid}, 32'd0);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        check("mid rst req", {31'd0, imem_req}, 32'd0);
        check("mid rst addr", imem_addr, 32'h0);
        check("mid rst valid", {31'd0, inst_valid}, 32'd0);
        reset    = 1'b0;
        redirect = 1'b0;
        #1;
        check("mid idle req", {31'd0, imem_req}, 32'd0);
        step();
        check("after idle req", {31'd0, imem_req}, 32'd1);
        check("after idle addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        step();
        expect_inst("restart", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the run in case the clocking above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
